// File: rtl/seq_load_buffer.sv
// Captures a sequence of player key codes into a DEPTH-entry buffer with indexed readback.
// Define SEQ_LOAD_BUFFER_EDGE_EN to capture on Access rising edges instead of levels.
module seq_load_buffer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Input,
  input  logic             Allow,
  input  logic             Access,
  input  logic [IDX_W-1:0] RdIdx,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] RdData,
  output logic [IDX_W:0]   Count,
  output logic             Full,
  output logic             Overflow,
  output logic             Loaded
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] output_q, output_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             loaded_q, loaded_d;
  logic             capture_c;
  logic             full_c;

`ifdef SEQ_LOAD_BUFFER_EDGE_EN
  // Access history sampled every cycle, independent of the load window.
  logic access_dly_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) access_dly_q <= 1'b0;
    else      access_dly_q <= Access;
  end

  assign capture_c = Access & ~access_dly_q;
`else
  assign capture_c = Access;
`endif

  assign full_c = (count_q == CNT_W'(DEPTH));

  // Clear outranks capture; a capture while full only flags overflow.
  always_comb begin
    mem_d      = mem_q;
    output_d   = output_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    loaded_d   = 1'b0;
    if (!Allow) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      output_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (capture_c) begin
      if (!full_c) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (count_q == CNT_W'(i)) mem_d[i] = Input;
        end
        output_d = Input;
        count_d  = count_q + CNT_W'(1);
        loaded_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      output_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      output_q   <= output_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      loaded_q   <= loaded_d;
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    RdData = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (RdIdx == IDX_W'(i)) RdData = mem_q[i];
    end
  end

  assign Output   = output_q;
  assign Count    = count_q;
  assign Full     = full_c;
  assign Overflow = overflow_q;
  assign Loaded   = loaded_q;

endmodule

// File: tb/tb_seq_load_buffer.sv
// Directed bench for seq_load_buffer: a DEPTH=8 instance plus a DEPTH=6 instance for bounds.
module tb_seq_load_buffer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] Input;
  logic       Allow;
  logic       Access;
  logic [2:0] RdIdx, RdIdx6;
  logic [3:0] Output, RdData, Output6, RdData6;
  logic [3:0] Count, Count6;
  logic       Full, Overflow, Loaded, Full6, Overflow6, Loaded6;

  int errors = 0;
  int checks = 0;
  int pulses;

  seq_load_buffer #(.WIDTH(4), .DEPTH(8), .IDX_W(3)) u_dut (
    .Clk(Clk), .Rst(Rst), .Input(Input), .Allow(Allow), .Access(Access),
    .RdIdx(RdIdx), .Output(Output), .RdData(RdData), .Count(Count),
    .Full(Full), .Overflow(Overflow), .Loaded(Loaded)
  );

  seq_load_buffer #(.WIDTH(4), .DEPTH(6), .IDX_W(3)) u_dut6 (
    .Clk(Clk), .Rst(Rst), .Input(Input), .Allow(Allow), .Access(Access),
    .RdIdx(RdIdx6), .Output(Output6), .RdData(RdData6), .Count(Count6),
    .Full(Full6), .Overflow(Overflow6), .Loaded(Loaded6)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b0; Input = '0; Allow = 1'b0; Access = 1'b0; RdIdx = '0; RdIdx6 = '0;
    #2;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_output", 32'(Output), 32'd0);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_loaded", 32'(Loaded), 32'd0);

    tick();
    Rst = 1'b1; Allow = 1'b1;
    tick();
    // Three captures, then async reset between edges
    for (int i = 1; i <= 3; i++) begin
      Input = 4'(i); Access = 1'b1; tick();
      Access = 1'b0; tick();
    end
    check("pre_rst_count", 32'(Count), 32'd3);
    Input = 4'h7; Access = 1'b1; tick(); Access = 1'b0;
    check("pre_rst_loaded", 32'(Loaded), 32'd1);
    #2 Rst = 1'b0;
    #1;
    check("midrst_count", 32'(Count), 32'd0);
    check("midrst_output", 32'(Output), 32'd0);
    check("midrst_loaded", 32'(Loaded), 32'd0);
    check("midrst_entry0", 32'(RdData), 32'd0);
    tick();
    Rst = 1'b1;
    Input = 4'hA; Access = 1'b1; tick(); Access = 1'b0;
    RdIdx = 3'd0; #1;
    check("post_rst_mem0", 32'(RdData), 32'hA);
    check("post_rst_count", 32'(Count), 32'd1);
    check("post_rst_output", 32'(Output), 32'hA);

    // Clear window before the fill
    Allow = 1'b0; tick(); Allow = 1'b1;
    check("clear0_count", 32'(Count), 32'd0);

    // Fill all eight entries with single-cycle strobes
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      Input = 4'(i); Access = 1'b1; tick();
      Access = 1'b0;
      if (Loaded) pulses++;
      check("fill_count", 32'(Count), 32'(i));
      Input = 4'hC; tick();
      check("fill_loaded_low", 32'(Loaded), 32'd0);
    end
    check("fill_pulses", 32'(pulses), 32'd8);
    check("fill_full", 32'(Full), 32'd1);
    check("fill_output", 32'(Output), 32'd8);
    for (int i = 0; i < 8; i++) begin
      RdIdx = 3'(i); #1;
      check("fill_rd", 32'(RdData), 32'(i + 1));
    end
    check("d6_full", 32'(Full6), 32'd1);
    check("d6_count", 32'(Count6), 32'd6);
    check("d6_overflow", 32'(Overflow6), 32'd1);

    // Capture attempt while full
    check("pre_ovf", 32'(Overflow), 32'd0);
    Input = 4'hF; Access = 1'b1; tick(); Access = 1'b0;
    check("ovf_flag", 32'(Overflow), 32'd1);
    check("ovf_count", 32'(Count), 32'd8);
    check("ovf_output", 32'(Output), 32'd8);
    check("ovf_loaded", 32'(Loaded), 32'd0);
    RdIdx = 3'd7; #1;
    check("ovf_mem7", 32'(RdData), 32'd8);
    tick(); tick();
    check("ovf_sticky", 32'(Overflow), 32'd1);

    // Window clear with a concurrent strobe
    Allow = 1'b0; Access = 1'b1; Input = 4'h3; tick();
    Allow = 1'b1; Access = 1'b0;
    check("wclr_count", 32'(Count), 32'd0);
    check("wclr_overflow", 32'(Overflow), 32'd0);
    check("wclr_loaded", 32'(Loaded), 32'd0);
    check("wclr_output", 32'(Output), 32'd0);
    check("wclr_full", 32'(Full), 32'd0);
    for (int i = 0; i < 8; i++) begin
      RdIdx = 3'(i); #1;
      check("wclr_rd", 32'(RdData), 32'd0);
    end
    tick();
    check("wclr_nocap", 32'(Count), 32'd0);

    // Access held high for three cycles
    pulses = 0;
    Input = 4'h5; Access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Loaded) pulses++;
    end
    Access = 1'b0;
    tick();
    if (Loaded) pulses++;
`ifdef SEQ_LOAD_BUFFER_EDGE_EN
    check("held_count", 32'(Count), 32'd1);
    check("held_pulses", 32'(pulses), 32'd1);
`else
    check("held_count", 32'(Count), 32'd3);
    check("held_pulses", 32'(pulses), 32'd3);
`endif
    check("held_output", 32'(Output), 32'd5);

    // Input changes without a capture have no effect
    Input = 4'h9; tick();
    check("idle_output", 32'(Output), 32'd5);

    // Readback bounds on the DEPTH=6 instance
    RdIdx6 = 3'd0; #1;
    check("d6_rd0", 32'(RdData6), 32'd5);
    RdIdx6 = 3'd6; #1;
    check("d6_rd6", 32'(RdData6), 32'd0);
    RdIdx6 = 3'd7; #1;
    check("d6_rd7", 32'(RdData6), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
